// File: rtl/inst_seq_if.sv
// Bus bundle for the instruction sequencer.
//   master side (program loader / controller) drives:
//     inst_in_v, inst_in  - program-load strobe and instruction word
//     clear, start        - discard program / begin execution
//     loop_cnt            - number of program passes
//     hold                - stall issue while the data memory is busy
//   slave side (inst_seq) drives:
//     inst_v, inst        - issued instruction to the data memory
//     rden, wben          - data-memory read / write-back enables
//     busy, done, err     - status (done is a one-cycle pulse, err is sticky)
`ifndef INST_WIDTH
`define INST_WIDTH 24
`endif

interface inst_seq_if;
  logic                   inst_in_v;
  logic [`INST_WIDTH-1:0] inst_in;
  logic                   clear;
  logic                   start;
  logic [7:0]             loop_cnt;
  logic                   hold;
  logic                   inst_v;
  logic [`INST_WIDTH-1:0] inst;
  logic                   rden;
  logic                   wben;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output inst_in_v, inst_in, clear, start, loop_cnt, hold,
    input  inst_v, inst, rden, wben, busy, done, err
  );

  modport slave (
    input  inst_in_v, inst_in, clear, start, loop_cnt, hold,
    output inst_v, inst, rden, wben, busy, done, err
  );
endinterface

// File: rtl/inst_seq.sv
// Instruction sequencer: holds a small program loaded word by word while
// idle, then replays it to the data memory one instruction per cycle
// (stallable by hold), raising a write-back enable WB_LAT cycles after each
// issue and pulsing done once the last write-back has been signalled.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - inst_seq_if.slave: load/clear/start/loop_cnt/hold inputs,
//            inst_v/inst/rden/wben/busy/done/err outputs
//
// Build option: define INST_SEQ_LOOP_EN to honour loop_cnt (multi-pass
// replay). Without it the program is replayed exactly once per start and
// loop_cnt is ignored.
`ifndef INST_WIDTH
`define INST_WIDTH 24
`endif

module inst_seq #(
  parameter int IM_DEPTH      = 64,
  parameter int IM_ADDR_WIDTH = 6,
  parameter int WB_LAT        = 6
) (
  input logic        clk,
  input logic        rst_n,
  inst_seq_if.slave  bus
);

  localparam int IW = `INST_WIDTH;
  localparam logic [IM_ADDR_WIDTH:0] DEPTH_C = (IM_ADDR_WIDTH+1)'(IM_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [IW-1:0]            im [0:IM_DEPTH-1];
  logic [IM_ADDR_WIDTH-1:0] wr_ptr;
  logic [IM_ADDR_WIDTH-1:0] rd_ptr;
  logic [IM_ADDR_WIDTH:0]   count;

  logic                     inst_v_r;
  logic [IW-1:0]            inst_r;
  logic                     rden_r;
  logic                     done_r;
  logic                     err_r;
  logic [WB_LAT-1:0]        wb_sr;
  logic [WB_LAT:0]          wb_pipe;

  logic is_idle, do_clear, do_start, load_ok, load_err;
  logic issue, last_entry, last_pass, drain_empty;
  logic busy_c, done_set;

  assign is_idle  = (state == IDLE);
  // clear has priority over start and over a simultaneous load
  assign do_clear = bus.clear && is_idle;
  assign do_start = bus.start && is_idle && !bus.clear && (count != '0);
  assign load_ok  = bus.inst_in_v && is_idle && !bus.clear && (count < DEPTH_C);
  assign load_err = bus.inst_in_v && !do_clear && (!is_idle || (count == DEPTH_C));

  assign issue      = (state == RUN) && !bus.hold;
  assign last_entry = ({1'b0, rd_ptr} == (count - 1'b1));

  // wb_pipe[0] is the live inst_v; the DRAIN exit looks one cycle ahead so
  // that done coincides with the first cycle after the final wben.
  assign wb_pipe     = {wb_sr, inst_v_r};
  assign drain_empty = ~|wb_pipe[WB_LAT-1:0];

`ifdef INST_SEQ_LOOP_EN
  logic [7:0] pass;
  logic [7:0] eff_loops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= '0;
      eff_loops <= 8'd1;
    end else if (do_start) begin
      pass      <= '0;
      eff_loops <= (bus.loop_cnt == 8'd0) ? 8'd1 : bus.loop_cnt;
    end else if (issue && last_entry && !last_pass) begin
      pass <= pass + 8'd1;
    end
  end

  assign last_pass = (pass == (eff_loops - 8'd1));
`else
  logic unused_loop_cnt;
  assign unused_loop_cnt = ^bus.loop_cnt;
  assign last_pass       = 1'b1;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_start) state_next = RUN;
      RUN:     if (issue && last_entry && last_pass) state_next = DRAIN;
      DRAIN:   if (drain_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_c   = (state != IDLE);
    done_set = (state == DRAIN) && drain_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_r <= 1'b0;
    else        done_r <= done_set;
  end

  // Program load bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
      err_r  <= 1'b0;
    end else if (do_clear) begin
      wr_ptr <= '0;
      count  <= '0;
      err_r  <= 1'b0;
    end else begin
      if (load_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end
      if (load_err) err_r <= 1'b1;
    end
  end

  // Program storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (load_ok) im[wr_ptr] <= bus.inst_in;
  end

  // Issue stage and write-back delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_v_r <= 1'b0;
      rden_r   <= 1'b0;
      inst_r   <= '0;
      rd_ptr   <= '0;
      wb_sr    <= '0;
    end else begin
      inst_v_r <= issue;
      rden_r   <= issue;
      if (do_start) begin
        rd_ptr <= '0;
      end else if (issue) begin
        inst_r <= im[rd_ptr];
        rd_ptr <= last_entry ? '0 : (rd_ptr + 1'b1);
      end
      wb_sr <= wb_pipe[WB_LAT-1:0];
    end
  end

  assign bus.inst_v = inst_v_r;
  assign bus.inst   = inst_r;
  assign bus.rden   = rden_r;
  assign bus.wben   = wb_sr[WB_LAT-1];
  assign bus.busy   = busy_c;
  assign bus.done   = done_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_inst_seq.sv
// Directed testbench for inst_seq. Time reference: edge T is the rising
// edge that samples start; "cycle k" outputs are sampled 1ns after edge
// T+k, and hold "at cycle k" is the value sampled by edge T+k.
`timescale 1ns/1ps
`ifndef INST_WIDTH
`define INST_WIDTH 24
`endif

module tb_inst_seq;

  localparam int WB = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_seq_if bus();

  inst_seq #(
    .IM_DEPTH(64),
    .IM_ADDR_WIDTH(6),
    .WB_LAT(WB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          slot_q[$];
  logic [31:0] val_q[$];
  int          hold_from = 100;
  int          hold_to   = 0;
  logic [31:0] last_inst_exp = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [23:0] w);
    bus.inst_in   = w;
    bus.inst_in_v = 1'b1;
    tick();
    bus.inst_in_v = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Replays the expected schedule in slot_q/val_q for ncyc cycles after
  // the start edge, driving hold over [hold_from, hold_to].
  task automatic check_run(input string tag, input int ncyc);
    int          last_slot;
    logic        e_iv, e_wb, e_dn, e_bz;
    logic [31:0] e_inst;
    last_slot = slot_q[slot_q.size()-1];
    bus.hold = (hold_from <= 1) && (1 <= hold_to);
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      e_iv   = 1'b0;
      e_wb   = 1'b0;
      e_inst = last_inst_exp;
      for (int i = 0; i < slot_q.size(); i++) begin
        if (slot_q[i] == k) begin
          e_iv   = 1'b1;
          e_inst = val_q[i];
        end
        if (slot_q[i] + WB == k) e_wb = 1'b1;
      end
      last_inst_exp = e_inst;
      e_dn = (k == last_slot + WB + 1);
      e_bz = (k <= last_slot + WB);
      check($sformatf("%s inst_v@T+%0d", tag, k), 32'(bus.inst_v), 32'(e_iv));
      check($sformatf("%s rden@T+%0d", tag, k), 32'(bus.rden), 32'(e_iv));
      check($sformatf("%s inst@T+%0d", tag, k), 32'(bus.inst), e_inst);
      check($sformatf("%s wben@T+%0d", tag, k), 32'(bus.wben), 32'(e_wb));
      check($sformatf("%s done@T+%0d", tag, k), 32'(bus.done), 32'(e_dn));
      check($sformatf("%s busy@T+%0d", tag, k), 32'(bus.busy), 32'(e_bz));
      bus.hold = (hold_from <= k + 1) && (k + 1 <= hold_to);
    end
    bus.hold = 1'b0;
  endtask

  task automatic set_single_pass();
    slot_q = '{1, 2, 3};
    val_q  = '{32'h000201, 32'h030405, 32'h060708};
  endtask

  initial begin
    bus.inst_in_v = 1'b0;
    bus.inst_in   = '0;
    bus.clear     = 1'b0;
    bus.start     = 1'b0;
    bus.loop_cnt  = 8'd1;
    bus.hold      = 1'b0;

    // Reset state
    #3;
    check("rst inst_v", 32'(bus.inst_v), 32'd0);
    check("rst inst", 32'(bus.inst), 32'd0);
    check("rst rden", 32'(bus.rden), 32'd0);
    check("rst wben", 32'(bus.wben), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic single-pass run
    load(24'h000201);
    load(24'h030405);
    load(24'h060708);
    check("load err", 32'(bus.err), 32'd0);
    do_start();
    set_single_pass();
    check_run("basic", 11);

    // Hold for two cycles; program persists from the previous run
    do_start();
    slot_q = '{1, 4, 5};
    val_q  = '{32'h000201, 32'h030405, 32'h060708};
    hold_from = 2;
    hold_to   = 3;
    check_run("hold", 14);
    hold_from = 100;
    hold_to   = 0;

    // loop_cnt = 2
    bus.loop_cnt = 8'd2;
    do_start();
    bus.loop_cnt = 8'd1;
`ifdef INST_SEQ_LOOP_EN
    slot_q = '{1, 2, 3, 4, 5, 6};
    val_q  = '{32'h000201, 32'h030405, 32'h060708,
               32'h000201, 32'h030405, 32'h060708};
`else
    set_single_pass();
`endif
    check_run("loop2", 15);

    // loop_cnt = 0 behaves as a single pass
    bus.loop_cnt = 8'd0;
    do_start();
    bus.loop_cnt = 8'd1;
    set_single_pass();
    check_run("loop0", 11);

    // Overflow: 64 loads fit, the 65th is dropped and sets err
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 64; i++) load(24'(i * 3 + 1));
    check("full count", 32'(dut.count), 32'd64);
    check("full err", 32'(bus.err), 32'd0);
    load(24'hFFFFFF);
    check("ovf count", 32'(dut.count), 32'd64);
    check("ovf err", 32'(bus.err), 32'd1);

    // clear together with start: clear wins, no run
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("clrstart busy", 32'(bus.busy), 32'd0);
    check("clrstart err", 32'(bus.err), 32'd0);
    check("clrstart count", 32'(dut.count), 32'd0);
    tick();
    check("clrstart busy2", 32'(bus.busy), 32'd0);
    check("clrstart inst_v", 32'(bus.inst_v), 32'd0);

    // start with an empty program is ignored
    do_start();
    tick();
    check("empty busy", 32'(bus.busy), 32'd0);
    check("empty inst_v", 32'(bus.inst_v), 32'd0);

    // Load outside IDLE sets err; reset mid-run aborts everything
    load(24'h000201);
    load(24'h030405);
    load(24'h060708);
    do_start();
    bus.inst_in   = 24'hABCDEF;
    bus.inst_in_v = 1'b1;
    tick();
    bus.inst_in_v = 1'b0;
    tick();
    check("run err", 32'(bus.err), 32'd1);
    check("run inst_v", 32'(bus.inst_v), 32'd1);
    check("run inst", 32'(bus.inst), 32'h030405);
    check("run busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst inst_v", 32'(bus.inst_v), 32'd0);
    check("arst inst", 32'(bus.inst), 32'd0);
    check("arst rden", 32'(bus.rden), 32'd0);
    check("arst wben", 32'(bus.wben), 32'd0);
    check("arst busy", 32'(bus.busy), 32'd0);
    check("arst done", 32'(bus.done), 32'd0);
    check("arst err", 32'(bus.err), 32'd0);
    check("arst count", 32'(dut.count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("post-rst wben@%0d", k), 32'(bus.wben), 32'd0);
      check($sformatf("post-rst done@%0d", k), 32'(bus.done), 32'd0);
      check($sformatf("post-rst busy@%0d", k), 32'(bus.busy), 32'd0);
    end

    // Restart after reload runs normally
    last_inst_exp = 32'd0;
    load(24'h000201);
    load(24'h030405);
    load(24'h060708);
    do_start();
    set_single_pass();
    check_run("restart", 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
